// File: rtl/nand_op_sequencer.sv
// rtl/nand_op_sequencer.sv - SPI-NAND op sequencer: command chains and status polling in front of mem_command
module nand_op_sequencer #(
  parameter int POLL_GAP_CLKS = 16,
  parameter int MAX_POLLS     = 4096
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_Op_Req,
  input  logic [1:0]  i_Op,
  input  logic [23:0] i_Row_Addr,
  input  logic [12:0] i_Col_Addr,
  output logic        o_Busy,
  output logic        o_Done,
  output logic [1:0]  o_Status,
  output logic [7:0]  o_Last_Feature,
  output logic [7:0]  o_Command,
  output logic [23:0] o_Addr_Data,
  output logic        o_CM_DV,
  input  logic        i_CM_Ready,
  input  logic [7:0]  i_Feature_Byte,
  input  logic        i_Feature_DV
);

  localparam int PW = $clog2(MAX_POLLS + 1);
  localparam int GW = $clog2(POLL_GAP_CLKS + 1);

  localparam logic [1:0] OP_RESET   = 2'd0;
  localparam logic [1:0] OP_READ    = 2'd1;
  localparam logic [1:0] OP_PROGRAM = 2'd2;
  localparam logic [1:0] OP_ERASE   = 2'd3;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_FAIL    = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  localparam logic [7:0] CMD_RESET       = 8'hFF;
  localparam logic [7:0] CMD_WREN        = 8'h06;
  localparam logic [7:0] CMD_GET_FEATURE = 8'h0F;
  localparam logic [7:0] CMD_PAGE_READ   = 8'h13;
  localparam logic [7:0] CMD_CACHE_READ  = 8'h03;
  localparam logic [7:0] CMD_PROG_LOAD1  = 8'h02;
  localparam logic [7:0] CMD_PROG_EXEC   = 8'h10;
  localparam logic [7:0] CMD_BLOCK_ERASE = 8'hD8;

  // Status register 0xC0 sits in the middle byte of the feature address word
  localparam logic [23:0] FEATURE_ADDR = {8'h00, 8'hC0, 8'h00};

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_START, S_WAIT_END, S_POLL_GAP, S_FINISH
  } state_t;

  state_t        state_q;
  logic [1:0]    op_q;
  logic [23:0]   row_q;
  logic [12:0]   col_q;
  logic [1:0]    step_q;
  logic [PW-1:0] poll_cnt_q;
  logic [GW-1:0] gap_cnt_q;
  logic          seen_q;
  logic [1:0]    fin_status_q;
  logic          busy_q;
  logic          done_q;
  logic          dv_q;
  logic [1:0]    status_q;
  logic [7:0]    last_feat_q;
  logic [7:0]    cmd_q;
  logic [23:0]   addr_q;

  logic [7:0]    step_cmd;
  logic [23:0]   step_addr;
  logic          step_poll;
  logic          step_last;
  logic          oip_now;
  logic          fail_now;

  // Map (op, step) onto the opcode/address to issue; unlisted steps are the status poll
  always_comb begin
    step_cmd  = CMD_GET_FEATURE;
    step_addr = FEATURE_ADDR;
    step_poll = 1'b1;
    step_last = 1'b0;
    case (op_q)
      OP_RESET: begin
        if (step_q == 2'd0) begin
          step_cmd  = CMD_RESET;
          step_addr = 24'h0;
          step_poll = 1'b0;
        end else begin
          step_last = 1'b1;
        end
      end
      OP_READ: begin
        if (step_q == 2'd0) begin
          step_cmd  = CMD_PAGE_READ;
          step_addr = row_q;
          step_poll = 1'b0;
        end else if (step_q == 2'd2) begin
          step_cmd  = CMD_CACHE_READ;
          step_addr = {11'b0, col_q};
          step_poll = 1'b0;
          step_last = 1'b1;
        end
      end
      OP_PROGRAM: begin
        case (step_q)
          2'd0: begin step_cmd = CMD_WREN;       step_addr = 24'h0;          step_poll = 1'b0; end
          2'd1: begin step_cmd = CMD_PROG_LOAD1; step_addr = {11'b0, col_q}; step_poll = 1'b0; end
          2'd2: begin step_cmd = CMD_PROG_EXEC;  step_addr = row_q;          step_poll = 1'b0; end
          default: step_last = 1'b1;
        endcase
      end
      OP_ERASE: begin
        case (step_q)
          2'd0: begin step_cmd = CMD_WREN;        step_addr = 24'h0; step_poll = 1'b0; end
          2'd1: begin step_cmd = CMD_BLOCK_ERASE; step_addr = row_q; step_poll = 1'b0; end
          default: step_last = 1'b1;
        endcase
      end
    endcase
  end

  // A status byte arriving in the same cycle CS releases must still count; a poll with no byte reads as busy
  assign oip_now  = i_Feature_DV ? i_Feature_Byte[0] : (seen_q ? last_feat_q[0] : 1'b1);
  assign fail_now = (op_q == OP_PROGRAM) ? (i_Feature_DV ? i_Feature_Byte[3] : last_feat_q[3]) :
                    (op_q == OP_ERASE)   ? (i_Feature_DV ? i_Feature_Byte[2] : last_feat_q[2]) :
                                           1'b0;

  // Sequencer FSM with all outputs registered
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= S_IDLE;
      op_q         <= 2'd0;
      row_q        <= 24'h0;
      col_q        <= 13'h0;
      step_q       <= 2'd0;
      poll_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      seen_q       <= 1'b0;
      fin_status_q <= ST_OK;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dv_q         <= 1'b0;
      status_q     <= ST_OK;
      last_feat_q  <= 8'h0;
      cmd_q        <= 8'h0;
      addr_q       <= 24'h0;
    end else begin
      dv_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // busy_q still high here only in the cycle right after o_Done; a request then is dropped
          busy_q <= 1'b0;
          if (i_Op_Req && !busy_q) begin
            busy_q     <= 1'b1;
            op_q       <= i_Op;
            row_q      <= i_Row_Addr;
            col_q      <= i_Col_Addr;
            step_q     <= 2'd0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i_CM_Ready) begin
            dv_q    <= 1'b1;
            cmd_q   <= step_cmd;
            addr_q  <= step_addr;
            seen_q  <= 1'b0;
            state_q <= S_WAIT_START;
          end
        end
        S_WAIT_START: begin
          if (step_poll && i_Feature_DV) begin
            last_feat_q <= i_Feature_Byte;
            seen_q      <= 1'b1;
          end
          if (!i_CM_Ready) state_q <= S_WAIT_END;
        end
        S_WAIT_END: begin
          if (step_poll && i_Feature_DV) begin
            last_feat_q <= i_Feature_Byte;
            seen_q      <= 1'b1;
          end
          if (i_CM_Ready) begin
            if (step_poll && oip_now) begin
              if (poll_cnt_q == PW'(MAX_POLLS - 1)) begin
                fin_status_q <= ST_TIMEOUT;
                state_q      <= S_FINISH;
              end else begin
                poll_cnt_q <= poll_cnt_q + PW'(1);
                gap_cnt_q  <= '0;
                state_q    <= S_POLL_GAP;
              end
            end else if (step_last) begin
              fin_status_q <= (step_poll && fail_now) ? ST_FAIL : ST_OK;
              state_q      <= S_FINISH;
            end else begin
              step_q  <= step_q + 2'd1;
              state_q <= S_ISSUE;
            end
          end
        end
        S_POLL_GAP: begin
          if (gap_cnt_q == GW'(POLL_GAP_CLKS - 1)) begin
            state_q <= S_ISSUE;
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
        S_FINISH: begin
          done_q   <= 1'b1;
          status_q <= fin_status_q;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_Busy         = busy_q;
  assign o_Done         = done_q;
  assign o_Status       = status_q;
  assign o_Last_Feature = last_feat_q;
  assign o_Command      = cmd_q;
  assign o_Addr_Data    = addr_q;
  assign o_CM_DV        = dv_q;

endmodule

// File: tb/tb_nand_op_sequencer.sv
// tb/tb_nand_op_sequencer.sv - self-checking bench for nand_op_sequencer
module tb_nand_op_sequencer;

  localparam int G  = 3;
  localparam int MP = 4;
  localparam logic [23:0] FA = 24'h00C000;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [1:0]  op;
  logic [23:0] row;
  logic [12:0] col;
  logic        o_Busy;
  logic        o_Done;
  logic [1:0]  o_Status;
  logic [7:0]  o_Last_Feature;
  logic [7:0]  o_Command;
  logic [23:0] o_Addr_Data;
  logic        o_CM_DV;
  logic        cm_ready;
  logic [7:0]  fbyte;
  logic        fdv;
  logic        rdy_m;
  logic        stall;

  assign cm_ready = rdy_m & ~stall;

  nand_op_sequencer #(.POLL_GAP_CLKS(G), .MAX_POLLS(MP)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Op_Req(req), .i_Op(op),
    .i_Row_Addr(row), .i_Col_Addr(col), .o_Busy(o_Busy), .o_Done(o_Done),
    .o_Status(o_Status), .o_Last_Feature(o_Last_Feature), .o_Command(o_Command),
    .o_Addr_Data(o_Addr_Data), .o_CM_DV(o_CM_DV), .i_CM_Ready(cm_ready),
    .i_Feature_Byte(fbyte), .i_Feature_DV(fdv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every command pulse and count done pulses
  logic [7:0]  log_cmd[$];
  logic [23:0] log_addr[$];
  int          log_cyc[$];
  int          done_total = 0;
  always @(negedge clk) begin
    if (o_CM_DV) begin
      log_cmd.push_back(o_Command);
      log_addr.push_back(o_Addr_Data);
      log_cyc.push_back(cyc);
    end
    if (o_Done) done_total = done_total + 1;
  end

  // Feature bytes handed out in order, one per GET_FEATURE
  logic [7:0] fsrc[0:63];
  int fwr = 0;
  int frd;

  // mem_command stand-in: drop ready after a command, return a status byte on polls, release
  initial begin
    bit poll;
    rdy_m = 1'b1; fdv = 1'b0; fbyte = 8'h00; frd = 0;
    forever begin
      @(negedge clk);
      if (o_CM_DV) begin
        poll  = (o_Command == 8'h0F);
        rdy_m = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (poll && frd < fwr) begin
          fbyte = fsrc[frd];
          frd   = frd + 1;
          fdv   = 1'b1;
        end
        @(negedge clk);
        fdv   = 1'b0;
        rdy_m = 1'b1;
      end
    end
  end

  int n_cmp = 0;
  int n_fail = 0;
  int req_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_feat(input logic [7:0] b);
    fsrc[fwr] = b;
    fwr = fwr + 1;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [23:0] r, input logic [12:0] c);
    @(negedge clk);
    op = o; row = r; col = c; req = 1'b1; req_cyc = cyc;
    @(negedge clk);
    req = 1'b0; op = ~o; row = ~r; col = ~c;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!o_Done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".done_seen"}, o_Done, 1);
  endtask

  task automatic finish_op(input string tag, input logic [1:0] st, input logic [7:0] lf);
    wait_done(tag);
    check({tag, ".status"}, o_Status, st);
    check({tag, ".last_feat"}, o_Last_Feature, lf);
    check({tag, ".busy_at_done"}, o_Busy, 1);
    @(negedge clk);
    check({tag, ".done_pulse"}, o_Done, 0);
    check({tag, ".busy_after"}, o_Busy, 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_log(input string tag, input int base, input int n,
                           input logic [0:7][7:0] cmds, input logic [0:7][23:0] addrs);
    check({tag, ".ncmd"}, log_cmd.size() - base, n);
    for (int k = 0; k < n && base + k < log_cmd.size(); k++) begin
      check($sformatf("%s.cmd%0d", tag, k), log_cmd[base+k], cmds[k]);
      if (cmds[k] != 8'h06 && cmds[k] != 8'hFF)
        check($sformatf("%s.addr%0d", tag, k), log_addr[base+k], addrs[k]);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, ".busy"}, o_Busy, 0);
    check({tag, ".done"}, o_Done, 0);
    check({tag, ".status"}, o_Status, 0);
    check({tag, ".last_feat"}, o_Last_Feature, 0);
    check({tag, ".cmd"}, o_Command, 0);
    check({tag, ".addr"}, o_Addr_Data, 0);
    check({tag, ".dv"}, o_CM_DV, 0);
  endtask

  typedef struct {
    logic [1:0]        op;
    logic [23:0]       row;
    logic [12:0]       col;
    int                n_feat;
    logic [0:3][7:0]   feats;
    int                n_cmd;
    logic [0:7][7:0]   cmds;
    logic [0:7][23:0]  addrs;
    logic [1:0]        status;
    logic [7:0]        last_feat;
  } vec_t;

  vec_t vecs[0:9];

  task automatic setv(input int i, input logic [1:0] o, input logic [23:0] r, input logic [12:0] c,
                      input int nf, input logic [0:3][7:0] f, input int nc,
                      input logic [0:7][7:0] cm, input logic [0:7][23:0] ad,
                      input logic [1:0] st, input logic [7:0] lf);
    vecs[i].op = o; vecs[i].row = r; vecs[i].col = c;
    vecs[i].n_feat = nf; vecs[i].feats = f; vecs[i].n_cmd = nc;
    vecs[i].cmds = cm; vecs[i].addrs = ad; vecs[i].status = st; vecs[i].last_feat = lf;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int dbase;
    string tag;

    // ERASE with two busy polls, PROGRAM with P_FAIL, READ, RESET, fail-bit selectivity, timeouts
    setv(0, 2'd3, 24'h000123, 13'h0000, 3, {8'h01, 8'h01, 8'h00, 8'h00}, 5,
         {8'h06, 8'hD8, 8'h0F, 8'h0F, 8'h0F, 24'h0}, {24'h0, 24'h000123, FA, FA, FA, 72'h0}, 2'd0, 8'h00);
    setv(1, 2'd2, 24'h00ABCD, 13'h01A5, 1, {8'h08, 24'h0}, 4,
         {8'h06, 8'h02, 8'h10, 8'h0F, 32'h0}, {24'h0, 24'h0001A5, 24'h00ABCD, FA, 96'h0}, 2'd1, 8'h08);
    setv(2, 2'd1, 24'h000777, 13'h0010, 2, {8'h01, 8'h00, 16'h0}, 4,
         {8'h13, 8'h0F, 8'h0F, 8'h03, 32'h0}, {24'h000777, FA, FA, 24'h000010, 96'h0}, 2'd0, 8'h00);
    setv(3, 2'd0, 24'h000000, 13'h0000, 1, {8'h00, 24'h0}, 2,
         {8'hFF, 8'h0F, 48'h0}, {24'h0, FA, 144'h0}, 2'd0, 8'h00);
    setv(4, 2'd3, 24'h00FFFF, 13'h0000, 1, {8'h04, 24'h0}, 3,
         {8'h06, 8'hD8, 8'h0F, 40'h0}, {24'h0, 24'h00FFFF, FA, 120'h0}, 2'd1, 8'h04);
    setv(5, 2'd2, 24'h123456, 13'h1FFF, 1, {8'h04, 24'h0}, 4,
         {8'h06, 8'h02, 8'h10, 8'h0F, 32'h0}, {24'h0, 24'h001FFF, 24'h123456, FA, 96'h0}, 2'd0, 8'h04);
    setv(6, 2'd3, 24'h0ABCDE, 13'h0000, 1, {8'h08, 24'h0}, 3,
         {8'h06, 8'hD8, 8'h0F, 40'h0}, {24'h0, 24'h0ABCDE, FA, 120'h0}, 2'd0, 8'h08);
    setv(7, 2'd1, 24'h000042, 13'h0100, 4, {8'h01, 8'h01, 8'h01, 8'h01}, 5,
         {8'h13, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 24'h0}, {24'h000042, FA, FA, FA, FA, 72'h0}, 2'd2, 8'h01);
    setv(8, 2'd0, 24'h000000, 13'h0000, 0, 32'h0, 5,
         {8'hFF, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 24'h0}, {24'h0, FA, FA, FA, FA, 72'h0}, 2'd2, 8'h01);
    setv(9, 2'd2, 24'h000001, 13'h0001, 4, {8'h09, 8'h09, 8'h09, 8'h09}, 7,
         {8'h06, 8'h02, 8'h10, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0},
         {24'h0, 24'h000001, 24'h000001, FA, FA, FA, FA, 24'h0}, 2'd2, 8'h09);

    rst_n = 1'b0; req = 1'b0; op = 2'd0; row = 24'h0; col = 13'h0; stall = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      tag   = $sformatf("v%0d", i);
      base  = log_cmd.size();
      dbase = done_total;
      for (int k = 0; k < vecs[i].n_feat; k++) push_feat(vecs[i].feats[k]);
      run_op(vecs[i].op, vecs[i].row, vecs[i].col);
      finish_op(tag, vecs[i].status, vecs[i].last_feat);
      check_log(tag, base, vecs[i].n_cmd, vecs[i].cmds, vecs[i].addrs);
      if (log_cmd.size() > base) check({tag, ".latency"}, log_cyc[base] - req_cyc, 2);
      for (int k = base + 1; k < log_cmd.size(); k++)
        if (log_cmd[k] == 8'h0F && log_cmd[k-1] == 8'h0F)
          check($sformatf("%s.poll_gap%0d", tag, k - base), log_cyc[k] - log_cyc[k-1], 5 + G);
      check({tag, ".ndone"}, done_total - dbase, 1);
    end

    // Reset during WAIT_END of PROG_EXEC, then a clean RESET op
    dbase = done_total;
    run_op(2'd2, 24'h00ABCD, 13'h01A5);
    begin
      int n = 0;
      while (!(o_CM_DV && o_Command == 8'h10) && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("rst.saw_exec", o_Command, 8'h10);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outs("rst.async");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rst.no_done", done_total - dbase, 0);
    base = log_cmd.size();
    push_feat(8'h00);
    run_op(2'd0, 24'h0, 13'h0);
    finish_op("rst.after", 2'd0, 8'h00);
    check_log("rst.after", base, 2, {8'hFF, 8'h0F, 48'h0}, {24'h0, FA, 144'h0});

    // Request during a busy READ is dropped and the latched addresses stay put
    base = log_cmd.size(); dbase = done_total;
    push_feat(8'h01); push_feat(8'h00);
    run_op(2'd1, 24'h000777, 13'h0010);
    repeat (4) @(negedge clk);
    op = 2'd3; row = 24'h000999; col = 13'h0AAA; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    finish_op("busyreq", 2'd0, 8'h00);
    repeat (30) @(negedge clk);
    check_log("busyreq", base, 4, {8'h13, 8'h0F, 8'h0F, 8'h03, 32'h0},
              {24'h000777, FA, FA, 24'h000010, 96'h0});
    check("busyreq.ndone", done_total - dbase, 1);

    // Request in the o_Done cycle is dropped; request in the cycle o_Busy falls is taken
    base = log_cmd.size(); dbase = done_total;
    push_feat(8'h00); push_feat(8'h00);
    run_op(2'd0, 24'h0, 13'h0);
    wait_done("edge1");
    op = 2'd3; row = 24'h000555; req = 1'b1;
    @(negedge clk);
    check("edge.busy_fell", o_Busy, 0);
    op = 2'd0; row = 24'h0; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("edge.accepted", o_Busy, 1);
    finish_op("edge2", 2'd0, 8'h00);
    check_log("edge", base, 4, {8'hFF, 8'h0F, 8'hFF, 8'h0F, 32'h0}, {24'h0, FA, 24'h0, FA, 96'h0});
    check("edge.ndone", done_total - dbase, 2);

    // Ready held low for 50 cycles: no command until it rises, then one pulse per command
    base = log_cmd.size();
    stall = 1'b1;
    push_feat(8'h00);
    run_op(2'd0, 24'h0, 13'h0);
    repeat (50) @(negedge clk);
    check("stall.no_dv", log_cmd.size() - base, 0);
    check("stall.busy", o_Busy, 1);
    stall = 1'b0;
    finish_op("stall", 2'd0, 8'h00);
    check_log("stall", base, 2, {8'hFF, 8'h0F, 48'h0}, {24'h0, FA, 144'h0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
